// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the Wishbone initiator bridge:
// FSM state enum, byte-mask constants and the read-modify-write byte merge.
package wb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INST_RD,
        DATA_RD,
        DATA_WR,
        RMW_RD,
        RMW_WR,
        DONE
    } wb_state_e;

    localparam logic [3:0] MASK_FULL = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    // Enabled lanes take the store data, the rest keep the read word.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] i_old,
        input logic [31:0] i_new,
        input logic [3:0]  i_mask
    );
        logic [31:0] w_out;
        for (int b = 0; b < 4; b++) begin
            w_out[8*b +: 8] = i_mask[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
        end
        return w_out;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-state counter for the bridge: counts cycles with a live strobe and no ack.
// Ports: clk, rst_n (sync, active-low), i_active (cyc&stb), i_ack, o_expired.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expired
);

    localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_waiting;

    assign w_waiting = i_active & ~i_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_waiting) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= '0;
        end
    end

    // Fires on the edge that would complete the TIMEOUT_CYCLES-th wait cycle.
    assign o_expired = w_waiting & (r_count == LIMIT);

endmodule

// File: rtl/wb_initiator_bridge.sv
// Arbitrates fetch/load/store requests onto one Wishbone classic initiator port,
// with read-modify-write for partial stores and a wait-state timeout abort.
// Ports: core side inst_*/data_* (req held until pulse), wb_* bus side, bus_err_o.
module wb_initiator_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_req_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic [DATA_WIDTH-1:0] inst_data_o,
    output logic                  inst_ready_o,
    input  logic                  data_rd_req_i,
    input  logic                  data_wr_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [3:0]            data_wmask_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_rd_ready_o,
    output logic                  data_wr_done_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_ack_i,
    output logic                  bus_err_o
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    wb_state_e             r_state, w_state_nxt;
    logic                  r_cyc, w_cyc_nxt;
    logic                  r_stb, w_stb_nxt;
    logic                  r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [3:0]            r_mask, w_mask_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic                  r_inst_rdy, w_inst_rdy_nxt;
    logic                  r_rd_rdy, w_rd_rdy_nxt;
    logic                  r_wr_done, w_wr_done_nxt;
    logic                  r_err, w_err_nxt;
    logic                  w_ack;
    logic                  w_expired;

    // Acks outside a live strobe are ignored.
    assign w_ack = wb_ack_i & r_cyc & r_stb;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_active (r_cyc & r_stb),
        .i_ack    (wb_ack_i),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_rdata    <= '0;
            r_inst_rdy <= 1'b0;
            r_rd_rdy   <= 1'b0;
            r_wr_done  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_stb      <= w_stb_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_mask     <= w_mask_nxt;
            r_rdata    <= w_rdata_nxt;
            r_inst_rdy <= w_inst_rdy_nxt;
            r_rd_rdy   <= w_rd_rdy_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_stb_nxt      = r_stb;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_mask_nxt     = r_mask;
        w_rdata_nxt    = r_rdata;
        w_inst_rdy_nxt = 1'b0;
        w_rd_rdy_nxt   = 1'b0;
        w_wr_done_nxt  = 1'b0;
        w_err_nxt      = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (data_wr_req_i) begin
                    w_addr_nxt  = data_addr_i & ALIGN;
                    w_wdata_nxt = data_wdata_i;
                    w_mask_nxt  = data_wmask_i;
                    if (data_wmask_i == MASK_NONE) begin
                        // Parks one cycle in DATA_WR with cyc low, then completes.
                        w_state_nxt = DATA_WR;
                    end else if (data_wmask_i == MASK_FULL) begin
                        w_state_nxt = DATA_WR;
                        w_cyc_nxt   = 1'b1;
                        w_stb_nxt   = 1'b1;
                        w_we_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = RMW_RD;
                        w_cyc_nxt   = 1'b1;
                        w_stb_nxt   = 1'b1;
                    end
                end else if (data_rd_req_i) begin
                    w_addr_nxt  = data_addr_i & ALIGN;
                    w_state_nxt = DATA_RD;
                    w_cyc_nxt   = 1'b1;
                    w_stb_nxt   = 1'b1;
                end else if (inst_req_i) begin
                    w_addr_nxt  = inst_addr_i & ALIGN;
                    w_state_nxt = INST_RD;
                    w_cyc_nxt   = 1'b1;
                    w_stb_nxt   = 1'b1;
                end
            end

            INST_RD, DATA_RD: begin
                if (w_ack || w_expired) begin
                    w_cyc_nxt      = 1'b0;
                    w_stb_nxt      = 1'b0;
                    w_rdata_nxt    = w_ack ? wb_data_i : '0;
                    w_err_nxt      = ~w_ack;
                    w_inst_rdy_nxt = (r_state == INST_RD);
                    w_rd_rdy_nxt   = (r_state == DATA_RD);
                    w_state_nxt    = DONE;
                end
            end

            RMW_RD: begin
                if (w_ack) begin
                    // Drop cyc for one cycle; RMW_WR re-raises it with the merged word.
                    w_cyc_nxt   = 1'b0;
                    w_stb_nxt   = 1'b0;
                    w_wdata_nxt = byte_merge(wb_data_i, r_wdata, r_mask);
                    w_state_nxt = RMW_WR;
                end else if (w_expired) begin
                    w_cyc_nxt     = 1'b0;
                    w_stb_nxt     = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_wr_done_nxt = 1'b1;
                    w_state_nxt   = DONE;
                end
            end

            DATA_WR, RMW_WR: begin
                if (w_ack || w_expired) begin
                    w_cyc_nxt     = 1'b0;
                    w_stb_nxt     = 1'b0;
                    w_we_nxt      = 1'b0;
                    w_err_nxt     = ~w_ack;
                    w_wr_done_nxt = 1'b1;
                    w_state_nxt   = DONE;
                end else if (!r_cyc) begin
                    if (r_state == DATA_WR) begin
                        w_wr_done_nxt = 1'b1;
                        w_state_nxt   = DONE;
                    end else begin
                        w_cyc_nxt = 1'b1;
                        w_stb_nxt = 1'b1;
                        w_we_nxt  = 1'b1;
                    end
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
                w_cyc_nxt   = 1'b0;
                w_stb_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

    assign wb_cyc_o        = r_cyc;
    assign wb_stb_o        = r_stb;
    assign wb_we_o         = r_we;
    assign wb_addr_o       = r_addr;
    assign wb_data_o       = r_wdata;
    assign inst_data_o     = r_rdata;
    assign data_rdata_o    = r_rdata;
    assign inst_ready_o    = r_inst_rdy;
    assign data_rd_ready_o = r_rd_rdy;
    assign data_wr_done_o  = r_wr_done;
    assign bus_err_o       = r_err;

endmodule

// File: doc/wb_initiator_bridge.md
WB_INITIATOR_BRIDGE -- requirements
Module: wb_initiator_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone/core address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, number of wait cycles before an unacknowledged cycle is aborted.
REQ-004 SHALL have port `clk`, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port `rst_n`, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port `inst_req_i`, input, 1 bit: instruction-fetch request, held high until `inst_ready_o`.
REQ-007 SHALL have port `inst_addr_i`, input, ADDR_WIDTH: fetch address.
REQ-008 SHALL have port `inst_data_o`, output, 32 bits: fetched word, valid while `inst_ready_o`=1.
REQ-009 SHALL have port `inst_ready_o`, output, 1 bit: one-cycle fetch-complete pulse.
REQ-010 SHALL have port `data_rd_req_i`, input, 1 bit: load request, held until `data_rd_ready_o`.
REQ-011 SHALL have port `data_wr_req_i`, input, 1 bit: store request, held until `data_wr_done_o`.
REQ-012 SHALL have port `data_addr_i`, input, ADDR_WIDTH: load/store address.
REQ-013 SHALL have port `data_wdata_i`, input, 32 bits: store data, byte lanes aligned to word.
REQ-014 SHALL have port `data_wmask_i`, input, 4 bits: byte-enable, bit i covering bits 8i+7:8i.
REQ-015 SHALL have port `data_rdata_o`, output, 32 bits: load word, valid while `data_rd_ready_o`=1.
REQ-016 SHALL have ports `data_rd_ready_o` and `data_wr_done_o`, outputs, 1 bit each: one-cycle completion pulses.
REQ-017 SHALL have ports `wb_cyc_o`, `wb_stb_o` and `wb_we_o`, outputs, 1 bit each: Wishbone classic controls.
REQ-018 SHALL have ports `wb_addr_o`, output, ADDR_WIDTH, and `wb_data_o`, output, 32 bits.
REQ-019 SHALL have ports `wb_data_i`, input, 32 bits, and `wb_ack_i`, input, 1 bit: responder return path (no byte-select line exists).
REQ-020 SHALL have port `bus_err_o`, output, 1 bit: one-cycle pulse on timeout abort.

Function
REQ-021 SHALL implement FSM states IDLE, INST_RD, DATA_RD, DATA_WR, RMW_RD, RMW_WR, DONE.
REQ-022 In IDLE, priority SHALL be data write > data read > instruction fetch; the granted request's address/data/mask SHALL be latched at the grant edge.
REQ-023 `wb_cyc_o`/`wb_stb_o` SHALL rise the cycle after grant (registered) and stay high, with address/data stable, until the ack edge or timeout.
REQ-024 `wb_ack_i` SHALL be honoured only while `wb_cyc_o`&`wb_stb_o`=1; stray acks are ignored.
REQ-025 `wb_addr_o` SHALL be {addr[ADDR_WIDTH-1:2],2'b00}; the low address bits are ignored.
REQ-026 On ack, cyc/stb/we SHALL deassert at that edge, and in DONE the matching ready/done pulse SHALL fire with the data registered from `wb_data_i`.
REQ-027 From DONE the FSM SHALL return to IDLE, giving at least one idle bus cycle between transactions.
REQ-028 Mask 4'b1111 SHALL produce a single write (DATA_WR).
REQ-029 Mask 4'b0000 SHALL produce no bus cycle, with `data_wr_done_o` pulsing two cycles after the request.
REQ-030 Any other mask SHALL perform read-modify-write: RMW_RD, then merge (masked bytes from `data_wdata_i`, others from the read word), then RMW_WR, with cyc deasserted for one cycle in between.
REQ-031 A wait counter SHALL count cycles with cyc high and no ack; on reaching TIMEOUT_CYCLES, cyc/stb SHALL drop, `bus_err_o` SHALL pulse, and the pending ready/done SHALL pulse with data 0.
REQ-032 A timeout in RMW_RD SHALL abort the write phase.
REQ-033 Requests arriving while busy SHALL wait; requests dropped before grant SHALL be ignored.
REQ-034 `wb_we_o` SHALL be 1 only in DATA_WR and RMW_WR.

Reset
REQ-035 With `rst_n`=0 at a clock edge, the FSM SHALL go to IDLE, counters SHALL clear, and all outputs SHALL be 0, including mid-transaction (cyc drops at that edge, no pulse issued).

Structure
REQ-036 Package wb_bridge_pkg SHALL hold the state enum, the mask constants MASK_FULL and MASK_NONE, and the byte-merge function.
REQ-037 The timeout counter SHALL be a single sub-module, wb_timeout_counter.

Verification
REQ-038 Fetch of 0x0000_0104 with ack after 3 cycles SHALL give wb_addr 0x104, then an inst_ready pulse with data 0xDEADBEEF.
REQ-039 Store with mask 4'b0100, wdata 0x00AB0000, and memory word 0x11223344 SHALL give a read, then a write of 0x11AB3344, then one done pulse.
REQ-040 Simultaneous fetch and load in IDLE SHALL service the load first, then the fetch; exactly one pulse each.
REQ-041 No ack with TIMEOUT_CYCLES=16 SHALL give bus_err and rd_ready 16 cycles after cyc rises, with data 0.
REQ-042 `rst_n` low during a DATA_WR wait SHALL drop cyc at the next edge, with no done pulse; a new fetch after release SHALL work.
REQ-043 Mask 0 SHALL give a done pulse with cyc never asserted.
